mc6502_trace_capture: RTL and testbench

//  Synthesizable bus-trace capture stage sitting directly downstream of the
//  MC6502 core. It snoops o_sync/o_rw/o_ab/io_db and emits one record per

---
 rtl/mc6502_trace_capture_pkg.sv | 36 +++
 rtl/mc6502_trace_fifo.sv | 79 +++++++
 rtl/mc6502_trace_capture.sv | 169 ++++++++++++++++
 tb/tb_mc6502_trace_capture.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc6502_trace_capture_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : mc6502_trace_capture_pkg                                  |
// | Purpose  : Shared types and constants for the MC6502 bus-trace       |
// |            capture stage (state encoding, record layout, helpers).   |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package mc6502_trace_capture_pkg;

  // Capture FSM encoding; the numeric values are exported on o_state.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_ARMED   = 2'b01,
    ST_TRACING = 2'b10,
    ST_STOPPED = 2'b11
  } trace_state_e;

  // One record per opcode fetch. Field order fixes the o_data bit layout:
  // pc [39:24], opcode [23:16], prev_len [15:8], prev_wr [7:0].
  typedef struct packed {
    logic [15:0] pc;
    logic [7:0]  opcode;
    logic [7:0]  prev_len;
    logic [7:0]  prev_wr;
  } trace_rec_t;

  localparam int         c_rec_w   = $bits(trace_rec_t);
  localparam logic [7:0] c_halt_op = 8'hFF;

  // Increment an 8-bit cycle counter when en is set, holding at 255.
  function automatic logic [7:0] sat_inc(input logic [7:0] v, input logic en);
    return (en && (v != 8'hFF)) ? (v + 8'd1) : v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mc6502_trace_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : mc6502_trace_fifo                                         |
// | Purpose  : Synchronous FIFO holding trace records. A push on a full  |
// |            FIFO is accepted only when a pop happens on the same edge.|
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module mc6502_trace_fifo #(
  parameter int WIDTH      = 40,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk_1mhz,
  input  logic                  rst_x,
  input  logic                  i_clear,
  input  logic                  i_push,
  input  logic [WIDTH-1:0]      i_wdata,
  input  logic                  i_pop,
  output logic [WIDTH-1:0]      o_rdata,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [DEPTH_LOG2:0]   o_count
);

  localparam int                  c_depth      = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] c_full_count = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [WIDTH-1:0]      mem_q [c_depth];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  w_push_ok;
  logic                  w_pop_ok;

  // The pointers alone cannot tell empty from full, so the count decides.
  assign o_full  = (count_q == c_full_count);
  assign o_empty = (count_q == '0);
  assign o_count = count_q;
  assign o_rdata = mem_q[rd_ptr_q];

  assign w_pop_ok  = i_pop & ~o_empty & ~i_clear;
  assign w_push_ok = i_push & ~i_clear & (~o_full | w_pop_ok);

  // Next pointer/count values; clear flushes regardless of push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (i_clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (w_push_ok) wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
      if (w_pop_ok)  rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
      count_d = count_q + {{DEPTH_LOG2{1'b0}}, w_push_ok}
                        - {{DEPTH_LOG2{1'b0}}, w_pop_ok};
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_1mhz or negedge rst_x) begin
    if (!rst_x) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Record storage; contents are only observed while the count is non-zero.
  always_ff @(posedge clk_1mhz) begin
    if (w_push_ok) mem_q[wr_ptr_q] <= i_wdata;
  end

endmodule
`default_nettype wire

// File: rtl/mc6502_trace_capture.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : mc6502_trace_capture                                      |
// | Purpose  : Snoops the MC6502 bus and queues one record per opcode    |
// |            fetch; flags halt ($FF), self-loop and FIFO overflow.     |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module mc6502_trace_capture
  import mc6502_trace_capture_pkg::*;
#(
  parameter int DEPTH_LOG2   = 4,
  parameter bit STOP_ON_FULL = 1'b0
) (
  input  logic        clk_1mhz,
  input  logic        rst_x,
  input  logic        i_enable,
  input  logic        i_clear,
  input  logic        i_sync,
  input  logic        i_rw,
  input  logic [15:0] i_ab,
  input  logic [7:0]  i_db,
  output logic        o_valid,
  output logic [39:0] o_data,
  input  logic        i_ready,
  output logic        o_halt,
  output logic        o_loop,
  output logic        o_overflow,
  output logic [1:0]  o_state
);

  trace_state_e        state_q, state_d;
  logic [7:0]          len_q, len_d;
  logic [7:0]          wr_q, wr_d;
  logic [15:0]         last_pc_q, last_pc_d;
  logic                halt_q, halt_d;
  logic                loop_q, loop_d;
  logic                ovf_q, ovf_d;

  logic                w_fetch;
  logic                w_first;
  logic                w_pop;
  logic                w_drop;
  logic                w_full;
  logic                w_empty;
  logic [DEPTH_LOG2:0] w_count;
  logic [c_rec_w-1:0]  w_rdata;
  trace_rec_t          w_rec;

  // A fetch only counts while capturing; disable and clear both win over it.
  assign w_fetch = i_sync & i_enable & ~i_clear &
                   ((state_q == ST_ARMED) | (state_q == ST_TRACING));
  assign w_first = (state_q == ST_ARMED);
  assign w_pop   = o_valid & i_ready;
  assign w_drop  = w_fetch & w_full & ~w_pop;

  // The first record after arming has no preceding window to report.
  assign w_rec = '{pc:       i_ab,
                   opcode:   i_db,
                   prev_len: w_first ? 8'h00 : len_q,
                   prev_wr:  w_first ? 8'h00 : wr_q};

  mc6502_trace_fifo #(
    .WIDTH      (c_rec_w),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk_1mhz (clk_1mhz),
    .rst_x    (rst_x),
    .i_clear  (i_clear),
    .i_push   (w_fetch & ~w_drop),
    .i_wdata  (w_rec),
    .i_pop    (w_pop),
    .o_rdata  (w_rdata),
    .o_full   (w_full),
    .o_empty  (w_empty),
    .o_count  (w_count)
  );

  assign o_valid    = (w_count != '0);
  assign o_data     = w_empty ? '0 : w_rdata;
  assign o_halt     = halt_q;
  assign o_loop     = loop_q;
  assign o_overflow = ovf_q;
  assign o_state    = state_q;

  // Next-state logic for the FSM, the window counters, last PC and flags.
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    wr_d      = wr_q;
    last_pc_d = last_pc_q;
    halt_d    = halt_q;
    loop_d    = loop_q;
    ovf_d     = ovf_q;

    if (i_clear) begin
      state_d   = i_enable ? ST_ARMED : ST_IDLE;
      len_d     = 8'h00;
      wr_d      = 8'h00;
      last_pc_d = 16'h0000;
      halt_d    = 1'b0;
      loop_d    = 1'b0;
      ovf_d     = 1'b0;
    end else begin
      // The fetch cycle itself opens the next measurement window.
      if (w_fetch) begin
        len_d     = 8'h01;
        wr_d      = {7'b0, ~i_rw};
        last_pc_d = i_ab;
      end else begin
        len_d = sat_inc(len_q, 1'b1);
        wr_d  = sat_inc(wr_q, ~i_rw);
      end

      if (w_drop) ovf_d = 1'b1;

      case (state_q)
        ST_IDLE: begin
          if (i_enable) state_d = ST_ARMED;
        end
        ST_ARMED: begin
          if (!i_enable)   state_d = ST_IDLE;
          else if (w_fetch) state_d = ST_TRACING;
        end
        ST_TRACING: begin
          if (!i_enable) begin
            state_d = ST_IDLE;
          end else if (w_fetch) begin
            if (i_db == c_halt_op) begin
              halt_d  = 1'b1;
              state_d = ST_STOPPED;
            end
            if (i_ab == last_pc_q) begin
              loop_d  = 1'b1;
              state_d = ST_STOPPED;
            end
            if (STOP_ON_FULL && w_drop) state_d = ST_STOPPED;
          end
        end
        ST_STOPPED: begin
          if (!i_enable) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State, counter and flag registers.
  always_ff @(posedge clk_1mhz or negedge rst_x) begin
    if (!rst_x) begin
      state_q   <= ST_IDLE;
      len_q     <= 8'h00;
      wr_q      <= 8'h00;
      last_pc_q <= 16'h0000;
      halt_q    <= 1'b0;
      loop_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      wr_q      <= wr_d;
      last_pc_q <= last_pc_d;
      halt_q    <= halt_d;
      loop_q    <= loop_d;
      ovf_q     <= ovf_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mc6502_trace_capture.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_mc6502_trace_capture                                   |
// | Purpose  : Three capture instances (16/nostop, 4/nostop, 4/stop)     |
// |            driven by one bus, each checked against a queue model.    |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_mc6502_trace_capture;

  logic        clk_1mhz = 1'b0;
  logic        rst_x, en, clr, sync, rw, rdy;
  logic [15:0] ab;
  logic [7:0]  db;

  logic        v  [3];
  logic [39:0] d  [3];
  logic        h  [3];
  logic        lp [3];
  logic        ov [3];
  logic [1:0]  st [3];

  int total = 0;
  int bad   = 0;

  always #5 clk_1mhz = ~clk_1mhz;

  mc6502_trace_capture #(.DEPTH_LOG2(4), .STOP_ON_FULL(1'b0)) u_dut0 (
    .clk_1mhz(clk_1mhz), .rst_x(rst_x), .i_enable(en), .i_clear(clr),
    .i_sync(sync), .i_rw(rw), .i_ab(ab), .i_db(db),
    .o_valid(v[0]), .o_data(d[0]), .i_ready(rdy),
    .o_halt(h[0]), .o_loop(lp[0]), .o_overflow(ov[0]), .o_state(st[0]));

  mc6502_trace_capture #(.DEPTH_LOG2(2), .STOP_ON_FULL(1'b0)) u_dut1 (
    .clk_1mhz(clk_1mhz), .rst_x(rst_x), .i_enable(en), .i_clear(clr),
    .i_sync(sync), .i_rw(rw), .i_ab(ab), .i_db(db),
    .o_valid(v[1]), .o_data(d[1]), .i_ready(rdy),
    .o_halt(h[1]), .o_loop(lp[1]), .o_overflow(ov[1]), .o_state(st[1]));

  mc6502_trace_capture #(.DEPTH_LOG2(2), .STOP_ON_FULL(1'b1)) u_dut2 (
    .clk_1mhz(clk_1mhz), .rst_x(rst_x), .i_enable(en), .i_clear(clr),
    .i_sync(sync), .i_rw(rw), .i_ab(ab), .i_db(db),
    .o_valid(v[2]), .o_data(d[2]), .i_ready(rdy),
    .o_halt(h[2]), .o_loop(lp[2]), .o_overflow(ov[2]), .o_state(st[2]));

  // ---------------- behavioural model ----------------
  // State numbers: 0 idle, 1 armed, 2 tracing, 3 stopped.
  logic [39:0] mq [3][$];
  int          m_st  [3];
  int          m_len [3];
  int          m_wr  [3];
  logic [15:0] m_last[3];
  logic        m_halt[3];
  logic        m_loop[3];
  logic        m_ovf [3];

  function automatic int depth_of(input int k);
    return (k == 0) ? 16 : 4;
  endfunction

  function automatic bit stop_of(input int k);
    return (k == 2);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      mq[k].delete();
      m_st[k] = 0; m_len[k] = 0; m_wr[k] = 0; m_last[k] = 16'h0;
      m_halt[k] = 1'b0; m_loop[k] = 1'b0; m_ovf[k] = 1'b0;
    end
  endtask

  task automatic model_step(input int k);
    bit          pop, fetch, dropped;
    logic [39:0] rec;
    pop = (mq[k].size() > 0) && rdy;
    if (clr) begin
      mq[k].delete();
      m_len[k] = 0; m_wr[k] = 0; m_last[k] = 16'h0;
      m_halt[k] = 1'b0; m_loop[k] = 1'b0; m_ovf[k] = 1'b0;
      m_st[k] = en ? 1 : 0;
      return;
    end
    fetch   = en && sync && (m_st[k] == 1 || m_st[k] == 2);
    dropped = 1'b0;
    if (pop) void'(mq[k].pop_front());
    if (fetch) begin
      if (m_st[k] == 1) rec = {ab, db, 16'h0000};
      else              rec = {ab, db, 8'(m_len[k]), 8'(m_wr[k])};
      if (mq[k].size() < depth_of(k)) mq[k].push_back(rec);
      else begin dropped = 1'b1; m_ovf[k] = 1'b1; end
    end
    if (!en) m_st[k] = 0;
    else if (m_st[k] == 0) m_st[k] = 1;
    else if (fetch) begin
      if (m_st[k] == 1) m_st[k] = 2;
      else begin
        if (db == 8'hFF)      begin m_halt[k] = 1'b1; m_st[k] = 3; end
        if (ab == m_last[k])  begin m_loop[k] = 1'b1; m_st[k] = 3; end
        if (dropped && stop_of(k)) m_st[k] = 3;
      end
    end
    if (fetch) begin
      m_len[k] = 1; m_wr[k] = rw ? 0 : 1; m_last[k] = ab;
    end else begin
      if (m_len[k] < 255) m_len[k]++;
      if (!rw && m_wr[k] < 255) m_wr[k]++;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk_1mhz or negedge rst_x);
      if (!rst_x) model_reset();
      else for (int k = 0; k < 3; k++) model_step(k);
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < 3; k++) begin
      logic [39:0] exp_d;
      logic        exp_v;
      exp_v = (mq[k].size() > 0);
      exp_d = exp_v ? mq[k][0] : 40'h0;
      chk($sformatf("valid%0d", k), {39'h0, v[k]},  {39'h0, exp_v});
      chk($sformatf("data%0d", k),  d[k],           exp_d);
      chk($sformatf("halt%0d", k),  {39'h0, h[k]},  {39'h0, m_halt[k]});
      chk($sformatf("loop%0d", k),  {39'h0, lp[k]}, {39'h0, m_loop[k]});
      chk($sformatf("ovf%0d", k),   {39'h0, ov[k]}, {39'h0, m_ovf[k]});
      chk($sformatf("state%0d", k), {38'h0, st[k]}, {38'h0, 2'(m_st[k])});
    end
  endtask

  task automatic tick();
    @(negedge clk_1mhz);
    compare_all();
    @(posedge clk_1mhz);
    #2;
  endtask

  task automatic bus(input logic s, input logic w, input logic [15:0] a,
                     input logic [7:0] dd, input logic r);
    sync = s; rw = w; ab = a; db = dd; rdy = r;
    tick();
  endtask

  task automatic clear_pulse(input logic s, input logic [15:0] a);
    clr = 1'b1;
    bus(s, 1'b1, a, 8'hA9, 1'b0);
    clr = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int nb, nc;
    rst_x = 1'b0; en = 1'b0; clr = 1'b0; sync = 1'b0; rw = 1'b1;
    ab = 16'h0; db = 8'h0; rdy = 1'b0;
    @(posedge clk_1mhz); #2;
    tick(); tick();
    chk("rst_state", {38'h0, st[0]}, 40'h0);
    chk("rst_valid", {39'h0, v[0]}, 40'h0);
    chk("rst_data", d[0], 40'h0);
    rst_x = 1'b1;
    tick();

    // Arm, then two fetches four clocks apart.
    en = 1'b1;
    bus(0, 1, 16'hFFFC, 8'h00, 0);
    chk("armed", {38'h0, st[0]}, 40'h1);
    bus(1, 1, 16'h0000, 8'hA9, 0);
    bus(0, 1, 16'h0001, 8'h10, 0);
    bus(0, 1, 16'h0001, 8'h10, 0);
    bus(0, 1, 16'h0001, 8'h10, 0);
    bus(1, 1, 16'h0002, 8'h55, 0);
    chk("t1_state", {38'h0, st[0]}, 40'h2);
    chk("t1_rec0", d[0], 40'h0000A90000);
    chk("t1_model0", mq[0][0], 40'h0000A90000);
    bus(0, 1, 16'h0003, 8'h00, 1);
    chk("t1_rec1", d[0], 40'h0002550400);
    bus(0, 1, 16'h0004, 8'h00, 1);

    // STA abs: one write cycle between fetches.
    bus(1, 1, 16'h0005, 8'h8D, 0);
    bus(0, 1, 16'h0006, 8'h34, 0);
    bus(0, 1, 16'h0007, 8'h12, 0);
    bus(0, 0, 16'h1234, 8'h77, 0);
    bus(1, 1, 16'h0008, 8'hEA, 0);
    bus(0, 1, 16'h0009, 8'h00, 1);
    chk("t2_rec", d[0], 40'h0008EA0401);
    bus(0, 1, 16'h0009, 8'h00, 1);

    // Halt opcode stops capture; later syncs push nothing.
    bus(1, 1, 16'h0010, 8'hFF, 0);
    chk("t3_halt", {39'h0, h[0]}, 40'h1);
    chk("t3_state", {38'h0, st[0]}, 40'h3);
    chk("t3_rec", d[0], 40'h0010FF0300);
    bus(1, 1, 16'h0012, 8'hA9, 0);
    bus(1, 1, 16'h0014, 8'hA9, 0);
    bus(0, 1, 16'h0015, 8'h00, 1);
    chk("t3_nopush", {39'h0, v[0]}, 40'h0);

    // Self-loop: JMP $0020 at $0020.
    clear_pulse(0, 16'h0000);
    chk("t4_clr_halt", {39'h0, h[0]}, 40'h0);
    bus(1, 1, 16'h0020, 8'h4C, 0);
    bus(0, 1, 16'h0021, 8'h20, 0);
    bus(0, 1, 16'h0022, 8'h00, 0);
    bus(1, 1, 16'h0020, 8'h4C, 0);
    chk("t4_loop", {39'h0, lp[0]}, 40'h1);
    chk("t4_state", {38'h0, st[0]}, 40'h3);
    bus(0, 1, 16'h0000, 8'h00, 1);
    chk("t4_rec", d[0], 40'h00204C0300);
    bus(0, 1, 16'h0000, 8'h00, 1);

    // Fill the depth-4 instances with six fetches and no consumer.
    clear_pulse(0, 16'h0000);
    for (int i = 0; i < 6; i++) bus(1, 1, 16'h0100 + 16'(2 * i), 8'hEA, 0);
    chk("t5_ovf1", {39'h0, ov[1]}, 40'h1);
    chk("t5_st1", {38'h0, st[1]}, 40'h2);
    chk("t5_ovf2", {39'h0, ov[2]}, 40'h1);
    chk("t5_st2", {38'h0, st[2]}, 40'h3);
    chk("t5_ovf0", {39'h0, ov[0]}, 40'h0);
    bus(1, 1, 16'h0200, 8'hEA, 1);
    nb = 0; nc = 0;
    for (int i = 0; i < 8; i++) begin
      if (v[1]) nb++;
      if (v[2]) nc++;
      bus(0, 1, 16'h0000, 8'h00, 1);
    end
    chk("t5_cnt1", 40'(nb), 40'd4);
    chk("t5_cnt2", 40'(nc), 40'd3);

    // Clear and fetch on the same edge; then disable mid-trace.
    clear_pulse(1, 16'h0300);
    chk("t6_valid1", {39'h0, v[1]}, 40'h0);
    chk("t6_ovf1", {39'h0, ov[1]}, 40'h0);
    chk("t6_st1", {38'h0, st[1]}, 40'h1);
    bus(1, 1, 16'h0300, 8'hA9, 0);
    bus(1, 1, 16'h0302, 8'hA9, 0);
    en = 1'b0;
    bus(0, 1, 16'h0000, 8'h00, 0);
    chk("t6_idle", {38'h0, st[0]}, 40'h0);
    chk("t6_held", {39'h0, v[0]}, 40'h1);
    chk("t6_rec", d[0], 40'h0300A90000);

    // Asynchronous reset mid-operation.
    rst_x = 1'b0;
    #1;
    chk("arst_valid", {39'h0, v[0]}, 40'h0);
    chk("arst_state", {38'h0, st[0]}, 40'h0);
    tick();
    rst_x = 1'b1;
    en = 1'b1;

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      logic s;
      s   = ($urandom_range(0, 3) == 0);
      clr = ($urandom_range(0, 39) == 0);
      if (!s && $urandom_range(0, 49) == 0) en = ~en;
      if ($urandom_range(0, 799) == 0) begin
        rst_x = 1'b0;
        tick();
        rst_x = 1'b1;
      end
      rw  = ($urandom_range(0, 4) != 0);
      ab  = 16'($urandom_range(0, 15));
      db  = ($urandom_range(0, 15) == 0) ? 8'hFF : 8'($urandom_range(0, 254));
      rdy = ((i % 400) < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 0);
      sync = s;
      tick();
    end
    clr = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
